hs_rx_buffer: RTL and testbench

- Downstream consumer stage for the 16-bit valid/ready source block.
- Accepts words over a valid/ready handshake into a small show-ahead FIFO.
- Re-presents buffered words on a second valid/ready output port.
- Keeps running statistics: accepted-word count and wrap-around sum. Flags upstream handshake-protocol violations.

---
 rtl/hs_rx_buffer.sv | 106 ++++++++++
 tb/tb_hs_rx_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_rx_buffer.sv
// Receive-side buffer: valid/ready input into a show-ahead FIFO, valid/ready output,
// plus accepted-word statistics and a sticky upstream handshake-violation flag.
module hs_rx_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [AW:0]       level,
  output logic [15:0]       acc_count,
  output logic [31:0]       acc_sum,
  output logic              proto_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic [15:0]       r_acc_count;
  logic [31:0]       r_acc_sum;
  logic              r_pend;
  logic [DATA_W-1:0] r_held;
  logic              r_proto_err;

  logic              w_push;
  logic              w_pop;
  logic              w_viol;

  // Full/empty come only from the registered level, so ready never depends on valid_in.
  assign ready_out  = (r_level != (AW+1)'(DEPTH));
  assign dout_valid = (r_level != (AW+1)'(0));
  assign w_push     = valid_in & ready_out;
  assign w_pop      = dout_valid & dout_ready;
  assign w_viol     = r_pend & (~valid_in | (data_in != r_held));

  assign level     = r_level;
  assign acc_count = r_acc_count;
  assign acc_sum   = r_acc_sum;
  assign proto_err = r_proto_err;

  // Head word, forced to zero when empty so stale entries never leak out.
  always_comb begin
    dout = '0;
    if (dout_valid) begin
      dout = r_mem[r_rd_ptr];
    end else begin
      dout = '0;
    end
  end

  // Storage array; a push in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Running statistics over accepted words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_count <= 16'd0;
      r_acc_sum   <= 32'd0;
    end else if (w_push) begin
      r_acc_count <= r_acc_count + 16'd1;
      r_acc_sum   <= r_acc_sum + 32'(data_in);
    end
  end

  // A stalled offer must stay valid with unchanged data until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_held      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_pend <= valid_in & ~ready_out;
      r_held <= data_in;
      if (w_viol) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Directed bench for hs_rx_buffer: hand-computed expectations checked with immediate assertions.
module tb_hs_rx_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  level;
  logic [15:0] acc_count;
  logic [31:0] acc_sum;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;

  hs_rx_buffer #(.DATA_W(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .acc_count  (acc_count),
    .acc_sum    (acc_sum),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_state(input string tag);
    chk({tag, ".level"},      32'(level),      32'd0);
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, ".ready_out"},  32'(ready_out),  32'd1);
    chk({tag, ".dout"},       32'(dout),       32'd0);
    chk({tag, ".acc_count"},  32'(acc_count),  32'd0);
    chk({tag, ".acc_sum"},    acc_sum,         32'd0);
    chk({tag, ".proto_err"},  32'(proto_err),  32'd0);
  endtask

  initial begin
    rst = 1'b1; data_in = 16'd0; valid_in = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_rst_state("reset");

    // 1: streaming with downstream always ready
    valid_in = 1'b1; dout_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 16'(i);
      tick();
      chk("t1.level", 32'(level), 32'd1);
      chk("t1.ready", 32'(ready_out), 32'd1);
      chk("t1.dout", 32'(dout), 32'(i));
      chk("t1.count", 32'(acc_count), 32'(i));
      chk("t1.sum", acc_sum, 32'(i * (i + 1) / 2));
    end
    valid_in = 1'b0;
    tick();
    chk("t1.drain_level", 32'(level), 32'd0);
    chk("t1.drain_dout", 32'(dout), 32'd0);
    chk("t1.proto", 32'(proto_err), 32'd0);

    // 2: fill to full, stall a fifth word, single pop frees one slot
    dout_ready = 1'b0; valid_in = 1'b1;
    for (int i = 8; i <= 11; i++) begin
      data_in = 16'(i);
      tick();
    end
    chk("t2.full_level", 32'(level), 32'd4);
    chk("t2.full_ready", 32'(ready_out), 32'd0);
    chk("t2.full_dout", 32'(dout), 32'h8);
    data_in = 16'h000C;
    tick(); tick();
    chk("t2.stall_level", 32'(level), 32'd4);
    chk("t2.stall_count", 32'(acc_count), 32'd9);
    chk("t2.stall_proto", 32'(proto_err), 32'd0);
    dout_ready = 1'b1;
    tick();
    chk("t2.pop_level", 32'(level), 32'd3);
    chk("t2.pop_ready", 32'(ready_out), 32'd1);
    chk("t2.pop_dout", 32'(dout), 32'h9);
    dout_ready = 1'b0;
    tick();
    chk("t2.push_level", 32'(level), 32'd4);
    chk("t2.push_count", 32'(acc_count), 32'd10);
    chk("t2.push_sum", acc_sum, 32'd65);
    chk("t2.proto", 32'(proto_err), 32'd0);

    // 3: full with pop and valid: pop only, then push+pop together
    data_in = 16'h000D; dout_ready = 1'b1;
    tick();
    chk("t3.pop_only_level", 32'(level), 32'd3);
    chk("t3.pop_only_dout", 32'(dout), 32'hA);
    chk("t3.pop_only_count", 32'(acc_count), 32'd10);
    tick();
    chk("t3.both_level", 32'(level), 32'd3);
    chk("t3.both_dout", 32'(dout), 32'hB);
    chk("t3.both_count", 32'(acc_count), 32'd11);
    valid_in = 1'b0;
    tick();
    chk("t3.order_c", 32'(dout), 32'hC);
    tick();
    chk("t3.order_d", 32'(dout), 32'hD);
    tick();
    chk("t3.empty_level", 32'(level), 32'd0);
    chk("t3.empty_valid", 32'(dout_valid), 32'd0);
    chk("t3.sum", acc_sum, 32'd78);
    chk("t3.proto", 32'(proto_err), 32'd0);

    // 4a: data changes while stalled
    dout_ready = 1'b0; valid_in = 1'b1;
    for (int i = 16; i <= 19; i++) begin
      data_in = 16'(i);
      tick();
    end
    data_in = 16'h1234;
    tick();
    chk("t4a.stall_ok", 32'(proto_err), 32'd0);
    data_in = 16'h1235;
    tick();
    chk("t4a.set", 32'(proto_err), 32'd1);
    valid_in = 1'b0; dout_ready = 1'b1;
    tick(); tick();
    chk("t4a.sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4a.cleared", 32'(proto_err), 32'd0);
    chk("t4a.level", 32'(level), 32'd0);

    // 4b: valid withdrawn while stalled
    dout_ready = 1'b0; valid_in = 1'b1;
    for (int i = 32; i <= 35; i++) begin
      data_in = 16'(i);
      tick();
    end
    data_in = 16'h5555;
    tick();
    chk("t4b.stall_ok", 32'(proto_err), 32'd0);
    valid_in = 1'b0;
    tick();
    chk("t4b.set", 32'(proto_err), 32'd1);
    dout_ready = 1'b1;
    tick(); tick();
    chk("t4b.sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rst_state("t4b.reset");

    // 5: statistics wrap
    valid_in = 1'b1; dout_ready = 1'b1; data_in = 16'hFFFF;
    for (int i = 0; i < 65537; i++) tick();
    chk("t5.count_wrap", 32'(acc_count), 32'd1);
    chk("t5.sum_wrap", acc_sum, 32'hFFFF_FFFF);
    chk("t5.level", 32'(level), 32'd1);
    chk("t5.dout", 32'(dout), 32'hFFFF);
    valid_in = 1'b0;
    tick();
    chk("t5.drain", 32'(level), 32'd0);

    // 6: reset mid-burst with a push offered in the reset cycle
    dout_ready = 1'b0; valid_in = 1'b1;
    for (int i = 49; i <= 51; i++) begin
      data_in = 16'(i);
      tick();
    end
    chk("t6.level3", 32'(level), 32'd3);
    chk("t6.dout", 32'(dout), 32'h31);
    rst = 1'b1; data_in = 16'h0099;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    chk_rst_state("t6.reset");
    tick();
    chk("t6.after_level", 32'(level), 32'd0);
    chk("t6.after_count", 32'(acc_count), 32'd0);
    chk("t6.after_dout", 32'(dout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
